// File: rtl/pb_hex_entry.sv
// Pushbutton synchroniser, debouncer and eight-digit hex entry register.
// Optional macro AUTOREPEAT_EN adds auto-repeat of digit/backspace keys while held.
module pb_hex_entry #(
  parameter int unsigned DEBOUNCE = 3,
  parameter int unsigned REPEAT   = 50
) (
  input  logic        hz100,
  input  logic        reset,
  input  logic [20:0] pb,
  output logic [31:0] entry,
  output logic [3:0]  count,
  output logic [31:0] result,
  output logic        done,
  output logic [4:0]  key_code,
  output logic        key_pulse
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    REL_WAIT
  } state_t;

  localparam logic [3:0] DB_LAST  = 4'(DEBOUNCE - 1);
  localparam logic [4:0] CODE_BS  = 5'd16;
  localparam logic [4:0] CODE_CLR = 5'd17;
  localparam logic [4:0] CODE_ENT = 5'd18;

  logic [18:0] sync1;
  logic [18:0] s;
  logic        any;
  logic [4:0]  top_code;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        accept;
  logic        repeat_fire;
  logic        fire;

  // pb[20:19] are not wired to any function.
  logic unused_pb;
  assign unused_pb = ^pb[20:19];

  // NOTE: sequential state always uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking (=) here would chain the two sync stages into one.
  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      s     <= '0;
    end else begin
      sync1 <= pb[18:0];
      s     <= sync1;
    end
  end

  assign any = |s;

  // NOTE: every always_comb output gets a default first; a path that leaves one
  // unassigned would infer a latch.
  always_comb begin
    top_code = 5'd0;
    for (int i = 0; i < 19; i++) begin
      if (s[i]) top_code = 5'(i);
    end
  end

  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (any) begin
          if (DEBOUNCE == 1) begin
            accept  = 1'b1;
            state_d = HELD;
          end else begin
            state_d = PRESS_WAIT;
            cnt_d   = 4'd1;
          end
        end
      end
      PRESS_WAIT: begin
        if (!any) begin
          state_d = IDLE;
        end else if (cnt_q == DB_LAST) begin
          accept  = 1'b1;
          state_d = HELD;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HELD: begin
        if (!any) begin
          state_d = REL_WAIT;
          cnt_d   = 4'd1;
        end
      end
      REL_WAIT: begin
        if (any) begin
          state_d = HELD;
        end else if (DEBOUNCE == 1 || cnt_q == DB_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef AUTOREPEAT_EN
  localparam logic [7:0] RPT_LAST = 8'(REPEAT - 1);
  logic [7:0] rpt_q;

  // Counter wraps every REPEAT held cycles; clear and enter let it wrap silently.
  assign repeat_fire = (state_q == HELD) && any && (rpt_q == RPT_LAST) &&
                       (top_code <= CODE_BS);

  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      rpt_q <= 8'd0;
    end else if (state_q == HELD && any) begin
      rpt_q <= (rpt_q == RPT_LAST) ? 8'd0 : rpt_q + 8'd1;
    end else begin
      rpt_q <= 8'd0;
    end
  end
`else
  assign repeat_fire = 1'b0;
`endif

  assign fire = accept | repeat_fire;

  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      entry     <= 32'd0;
      count     <= 4'd0;
      result    <= 32'd0;
      done      <= 1'b0;
      key_code  <= 5'd0;
      key_pulse <= 1'b0;
    end else begin
      key_pulse <= fire;
      done      <= fire && (top_code == CODE_ENT);
      if (fire) begin
        key_code <= top_code;
        case (top_code)
          CODE_ENT: begin
            result <= entry;
            entry  <= 32'd0;
            count  <= 4'd0;
          end
          CODE_CLR: begin
            entry <= 32'd0;
            count <= 4'd0;
          end
          CODE_BS: begin
            if (count != 4'd0) begin
              entry <= {4'h0, entry[31:4]};
              count <= count - 4'd1;
            end
          end
          default: begin
            entry <= {entry[27:0], top_code[3:0]};
            if (count != 4'd8) count <= count + 4'd1;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/pb_hex_entry.md
Name: pb_hex_entry

Overview:
- Input-side counterpart to the seven-segment display path. It turns raw pushbutton presses into an eight-digit hex entry register that the display decoders show.
- It synchronises and debounces the 21 pushbuttons and encodes the accepted press into a key code.
- Digit keys shift hex digits into the entry register. Edit keys and a commit key control it.
- Sits between top-level pb[20:0] and the decode_led instances. It runs on the 100 Hz board clock.

Parameters:
DEBOUNCE, 3, consecutive cycles the synchronised "any key" level must hold to accept a press, and must stay low to re-arm; legal range 1..15
REPEAT, 50, auto-repeat period in cycles (used only with AUTOREPEAT_EN); legal range 2..255

Ports:
hz100  input  1  system clock
reset  input  1  asynchronous reset, active-high
pb  input  21  raw pushbuttons: [15:0] = hex digit 0-F, [16] = backspace, [17] = clear, [18] = enter, [20:19] = ignored
entry  output  32  current entry; digit n in bits [4n+3:4n]; newest digit in [3:0]
count  output  4  number of digits entered, 0..8
result  output  32  last committed entry
done  output  1  one-cycle pulse when result is updated
key_code  output  5  code of the last accepted key (pb index)
key_pulse  output  1  one-cycle pulse per accepted key event

Behaviour:
- Reset: one clock, asynchronous and active-high. The clock port is named hz100 and the reset port is named reset, as elsewhere in the codebase. While reset is high, all of the following are 0: entry, count, result, done, key_code, key_pulse, synchroniser flops, debounce counter. The FSM is in IDLE. Reset mid-press abandons the press; a key still held after release of reset must pass the full debounce before it is accepted.
- Synchroniser: pb[18:0] passes through 2 flops to give s[18:0]. The "any" signal is the OR of s[18:0]. pb[20:19] are never sampled.
- Debounce FSM, with counter cnt (4 bits):
  - IDLE: if any, go to PRESS_WAIT with cnt=1. Exception: if DEBOUNCE==1, accept immediately and go to HELD.
  - PRESS_WAIT: if !any, go to IDLE. Else if cnt==DEBOUNCE-1, accept and go to HELD. Else cnt++.
  - HELD: if !any, go to REL_WAIT with cnt=1. Otherwise stay; no further events are generated.
  - REL_WAIT: if any, go back to HELD. Else if cnt==DEBOUNCE-1 (or DEBOUNCE==1), go to IDLE. Else cnt++.
- Accept:
  - key_code is the highest index set in s[18:0] on the accepting edge.
  - key_pulse is high for the single cycle after the accepting edge.
  - The entry action below is applied on that same edge.
  - Latency from a pb edge to key_pulse high is 2+DEBOUNCE cycles.
- Entry actions:
  - Digit d, count<8: entry = {entry[27:0], d}; count++.
  - Digit d, count==8: same shift. The oldest digit is dropped and count stays 8.
  - Backspace: entry = {4'h0, entry[31:4]}; count-- if count>0. At count==0 nothing changes.
  - Clear: entry=0, count=0.
  - Enter: result=entry; done pulses for one cycle; entry=0; count=0. Enter with count==0 still commits 0 and still pulses done.
- Simultaneous keys: priority by highest index, so enter beats clear, clear beats backspace, backspace beats digits, and F beats 0. Keys added or removed while in HELD are ignored until the next full release.
- Outputs are registered; there are no combinational paths from pb to any output.

Optional Feature:
AUTOREPEAT_EN
- Defined:
  - In HELD, a 8-bit repeat counter runs.
  - After REPEAT cycles with the key held, the current highest s index is re-accepted: key_pulse fires and the action is applied. Then every REPEAT cycles thereafter.
  - This applies only to digit and backspace codes. Clear and enter never repeat.
  - The counter resets on leaving HELD.
- Not defined: HELD never generates events, and the repeat counter logic is absent.

Test Plan:
- Reset, then DEBOUNCE=3: hold pb[5] for 10 cycles, then release -> exactly 1 key_pulse, 5 cycles after pb rises; key_code=5, entry=0x00000005, count=1.
- Glitch: pb[7] high for 2 cycles, then low for 10 -> no key_pulse; entry and count unchanged.
- Nine digit presses 1,2,...,9, each held for 6 cycles with 6-cycle gaps -> entry=0x23456789, count=8. Then backspace -> entry=0x02345678, count=7.
- Enter after entering A,B: pb[10], pb[11], then pb[18] -> result=0x000000AB, done high for exactly 1 cycle, entry=0, count=0. Enter again -> result=0, done pulses.
- pb[3] and pb[17] pressed together with entry=0x12 -> clear wins: entry=0, count=0, key_code=17. Then pb[3] released while pb[17] is still held -> no new event.
- Assert reset in PRESS_WAIT while pb[4] is held, deassert with pb[4] still held -> all outputs 0 during reset; the press is accepted 2+DEBOUNCE cycles after release, not earlier. With AUTOREPEAT_EN and REPEAT=4: hold pb[2] for 14 cycles after acceptance -> 1 accept plus 3 repeats, entry=0x2222, count=4.
